// File: rtl/spi_host_data_sequencer.sv
// Byte sequencer between the SPI_HOST TX/RX data FIFOs and the byte-wide shift engine.
// Unpacks {data, be} TX words into enabled bytes and packs RX bytes into 32-bit words.
module spi_host_data_sequencer #(
  parameter int unsigned LenW = 9
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            sw_rst_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [LenW-1:0] cmd_len_i,
  input  logic [1:0]      cmd_dir_i,
  input  logic [31:0]     core_tx_data_i,
  input  logic [3:0]      core_tx_be_i,
  input  logic            core_tx_valid_i,
  output logic            core_tx_ready_o,
  output logic [31:0]     core_rx_data_o,
  output logic            core_rx_valid_o,
  input  logic            core_rx_ready_i,
  output logic [7:0]      sr_tx_byte_o,
  output logic            sr_tx_valid_o,
  input  logic            sr_tx_ready_i,
  input  logic [7:0]      sr_rx_byte_i,
  input  logic            sr_rx_valid_i,
  output logic            sr_rx_ready_o,
  output logic            busy_o
);

  localparam int unsigned CntW = LenW + 1;

  typedef enum logic [1:0] {StIdle, StActive, StFlush} state_e;

  state_e            state_q, state_d;
  logic [LenW-1:0]   len_q, len_d;
  logic [1:0]        dir_q, dir_d;
  logic [CntW-1:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [31:0]       tx_data_q, tx_data_d;
  logic [3:0]        tx_be_q, tx_be_d;
  logic [31:0]       rx_word_q, rx_word_d;
  logic              rx_full_q, rx_full_d;

  logic [CntW-1:0]   seg_bytes;
  logic              cmd_hs, tx_done, rx_done, active;
  logic              tx_send, tx_pop, rx_acc, rx_push;
  logic [1:0]        tx_lane, rx_lane;

  assign seg_bytes = {1'b0, len_q} + {{LenW{1'b0}}, 1'b1};
  assign active    = (state_q == StActive);
  assign tx_done   = !dir_q[1] || (tx_cnt_q == seg_bytes);
  assign rx_done   = !dir_q[0] || (rx_cnt_q == seg_bytes);
  assign rx_lane   = rx_cnt_q[1:0];

  // Lowest enabled lane is served next; disabled lanes cost no cycles.
  always_comb begin
    tx_lane = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (tx_be_q[i]) tx_lane = 2'(i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      len_q     <= '0;
      dir_q     <= '0;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      tx_data_q <= '0;
      tx_be_q   <= '0;
      rx_word_q <= '0;
      rx_full_q <= 1'b0;
    end else if (sw_rst_i) begin
      state_q   <= StIdle;
      len_q     <= '0;
      dir_q     <= '0;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      tx_data_q <= '0;
      tx_be_q   <= '0;
      rx_word_q <= '0;
      rx_full_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      dir_q     <= dir_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      tx_data_q <= tx_data_d;
      tx_be_q   <= tx_be_d;
      rx_word_q <= rx_word_d;
      rx_full_q <= rx_full_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_hs && (cmd_dir_i != 2'b00)) state_d = StActive;
      end
      StActive: begin
        // A full word must drain before the segment may close.
        if (tx_done && rx_done && (!rx_full_q || rx_push)) begin
          state_d = (rx_lane != 2'd0) ? StFlush : StIdle;
        end
      end
      StFlush: begin
        if (core_rx_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_ready_o     = (state_q == StIdle);
    busy_o          = (state_q != StIdle);
    core_tx_ready_o = active && (tx_be_q == 4'd0) && !tx_done && core_tx_valid_i;
    sr_tx_valid_o   = active && (tx_be_q != 4'd0) && !tx_done;
    sr_tx_byte_o    = tx_data_q[{tx_lane, 3'b000} +: 8];
    core_rx_valid_o = rx_full_q || (state_q == StFlush);
    core_rx_data_o  = rx_word_q;
    sr_rx_ready_o   = active && !rx_done && (!rx_full_q || core_rx_ready_i);
  end

  assign cmd_hs  = cmd_valid_i && cmd_ready_o;
  assign tx_send = sr_tx_valid_o && sr_tx_ready_i;
  assign tx_pop  = core_tx_ready_o;
  assign rx_acc  = sr_rx_valid_i && sr_rx_ready_o;
  assign rx_push = core_rx_valid_o && core_rx_ready_i;

  always_comb begin
    len_d     = len_q;
    dir_d     = dir_q;
    tx_cnt_d  = tx_cnt_q;
    rx_cnt_d  = rx_cnt_q;
    tx_data_d = tx_data_q;
    tx_be_d   = tx_be_q;
    rx_word_d = rx_word_q;
    rx_full_d = rx_full_q;

    if (cmd_hs) begin
      len_d    = cmd_len_i;
      dir_d    = cmd_dir_i;
      tx_cnt_d = '0;
      rx_cnt_d = '0;
    end

    if (tx_pop) begin
      tx_data_d = core_tx_data_i;
      tx_be_d   = core_tx_be_i;
    end else if (tx_send) begin
      tx_be_d[tx_lane] = 1'b0;
      tx_cnt_d         = tx_cnt_q + {{LenW{1'b0}}, 1'b1};
    end

    if (rx_push) begin
      rx_word_d = '0;
      rx_full_d = 1'b0;
    end
    if (rx_acc) begin
      // Lane 0 starts a fresh word so unfilled upper lanes read as zero.
      if (rx_lane == 2'd0) rx_word_d = {24'd0, sr_rx_byte_i};
      else rx_word_d[{rx_lane, 3'b000} +: 8] = sr_rx_byte_i;
      if (rx_lane == 2'd3) rx_full_d = 1'b1;
      rx_cnt_d = rx_cnt_q + {{LenW{1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_spi_host_data_sequencer.sv
// Directed bench for spi_host_data_sequencer: TX unpacking, RX packing/flush, sw reset, dummy.
module tb_spi_host_data_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, sw_rst;
  logic        cmd_valid, cmd_ready;
  logic [8:0]  cmd_len;
  logic [1:0]  cmd_dir;
  logic [31:0] core_tx_data;
  logic [3:0]  core_tx_be;
  logic        core_tx_valid, core_tx_ready;
  logic [31:0] core_rx_data;
  logic        core_rx_valid, core_rx_ready;
  logic [7:0]  sr_tx_byte;
  logic        sr_tx_valid, sr_tx_ready;
  logic [7:0]  sr_rx_byte;
  logic        sr_rx_valid, sr_rx_ready;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [35:0] tx_mem [8];
  logic [3:0]  tx_rd = 4'd0;
  logic [3:0]  tx_wr = 4'd0;
  int          tx_pops = 0;
  logic [7:0]  tx_bytes [$];
  logic [31:0] rx_words [$];

  always #5 clk = ~clk;

  assign core_tx_valid = (tx_rd != tx_wr);
  assign core_tx_data  = tx_mem[tx_rd[2:0]][35:4];
  assign core_tx_be    = tx_mem[tx_rd[2:0]][3:0];

  spi_host_data_sequencer #(.LenW(9)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .sw_rst_i        (sw_rst),
    .cmd_valid_i     (cmd_valid),
    .cmd_ready_o     (cmd_ready),
    .cmd_len_i       (cmd_len),
    .cmd_dir_i       (cmd_dir),
    .core_tx_data_i  (core_tx_data),
    .core_tx_be_i    (core_tx_be),
    .core_tx_valid_i (core_tx_valid),
    .core_tx_ready_o (core_tx_ready),
    .core_rx_data_o  (core_rx_data),
    .core_rx_valid_o (core_rx_valid),
    .core_rx_ready_i (core_rx_ready),
    .sr_tx_byte_o    (sr_tx_byte),
    .sr_tx_valid_o   (sr_tx_valid),
    .sr_tx_ready_i   (sr_tx_ready),
    .sr_rx_byte_i    (sr_rx_byte),
    .sr_rx_valid_i   (sr_rx_valid),
    .sr_rx_ready_o   (sr_rx_ready),
    .busy_o          (busy)
  );

  // Handshake recorder; also models the TX FIFO read pointer.
  always @(posedge clk) begin
    if (sr_tx_valid && sr_tx_ready) tx_bytes.push_back(sr_tx_byte);
    if (core_tx_valid && core_tx_ready) begin
      tx_pops <= tx_pops + 1;
      tx_rd   <= tx_rd + 4'd1;
    end
    if (core_rx_valid && core_rx_ready) rx_words.push_back(core_rx_data);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic issue_cmd(input logic [1:0] dir, input logic [8:0] len);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_len   = len;
    #1;
    check("cmd_ready_at_issue", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic send_rx(input logic [7:0] b);
    int  n = 0;
    logic done = 1'b0;
    sr_rx_valid = 1'b1;
    sr_rx_byte  = b;
    while (!done && n < 50) begin
      #1;
      if (sr_rx_ready) done = 1'b1;
      @(negedge clk);
      n++;
    end
    sr_rx_valid = 1'b0;
    check("rx_send_timeout", done, 1);
  endtask

  task automatic check_tx(input string tag, input logic [63:0] exp, input int n);
    check({tag, "_count"}, tx_bytes.size(), n);
    for (int i = 0; i < n; i++) begin
      check({tag, "_byte"}, tx_bytes[i], exp[8*i +: 8]);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) tx_mem[i] = '0;
    rst_n = 1'b0; sw_rst = 1'b0;
    cmd_valid = 1'b0; cmd_len = '0; cmd_dir = '0;
    core_rx_ready = 1'b0; sr_tx_ready = 1'b0;
    sr_rx_byte = '0; sr_rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_tx_pop", core_tx_ready, 0);
    check("rst_sr_tx_valid", sr_tx_valid, 0);
    check("rst_sr_tx_byte", sr_tx_byte, 0);
    check("rst_rx_valid", core_rx_valid, 0);
    check("rst_rx_data", core_rx_data, 0);
    check("rst_sr_rx_ready", sr_rx_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // TX-only len=5 across two full words; lanes 77,88 stay behind.
    tx_mem[0] = {32'h44332211, 4'hF};
    tx_mem[1] = {32'h88776655, 4'hF};
    tx_wr = 4'd2;
    sr_tx_ready = 1'b1;
    issue_cmd(2'b10, 9'd5);
    check("tx1_pop_cycle", core_tx_ready, 1);
    check("tx1_no_byte_yet", sr_tx_valid, 0);
    @(negedge clk);
    check("tx1_first_valid", sr_tx_valid, 1);
    check("tx1_first_byte", sr_tx_byte, 8'h11);
    wait_idle();
    check_tx("tx1", 64'h0000_6655_4433_2211, 6);
    check("tx1_pops", tx_pops, 2);

    tx_bytes.delete();
    issue_cmd(2'b10, 9'd1);
    wait_idle();
    check_tx("tx_retained", 64'h8877, 2);
    check("tx_retained_pops", tx_pops, 2);

    // be=0000 word is discarded, then sparse lanes 0 and 2 only.
    tx_bytes.delete();
    tx_mem[2] = {32'hFFFFFFFF, 4'b0000};
    tx_mem[3] = {32'hDDCCBBAA, 4'b0101};
    tx_wr = 4'd4;
    issue_cmd(2'b10, 9'd1);
    wait_idle();
    check_tx("tx_sparse", 64'hCCAA, 2);
    check("tx_sparse_pops", tx_pops, 4);

    // RX-only len=5: one full push, then a flushed partial word.
    rx_words.delete();
    core_rx_ready = 1'b1;
    issue_cmd(2'b01, 9'd5);
    send_rx(8'h01); send_rx(8'h02); send_rx(8'h03); send_rx(8'h04);
    check("rx_full_valid", core_rx_valid, 1);
    check("rx_full_data", core_rx_data, 32'h04030201);
    send_rx(8'h05); send_rx(8'h06);
    check("rx_pre_flush_busy", busy, 1);
    check("rx_pre_flush_valid", core_rx_valid, 0);
    @(negedge clk);
    check("rx_flush_valid", core_rx_valid, 1);
    check("rx_flush_data", core_rx_data, 32'h00000605);
    check("rx_flush_busy", busy, 1);
    @(negedge clk);
    check("rx_busy_falls", busy, 0);
    check("rx_push_count", rx_words.size(), 2);
    check("rx_word0", rx_words[0], 32'h04030201);
    check("rx_word1", rx_words[1], 32'h00000605);

    // Bidir len=3 with RX FIFO back-pressure after the 4th byte.
    rx_words.delete();
    tx_bytes.delete();
    tx_mem[4] = {32'h0D0C0B0A, 4'hF};
    tx_wr = 4'd5;
    issue_cmd(2'b11, 9'd3);
    send_rx(8'hA1); send_rx(8'hA2); send_rx(8'hA3); send_rx(8'hA4);
    core_rx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bidir_hold_valid", core_rx_valid, 1);
      check("bidir_hold_data", core_rx_data, 32'hA4A3A2A1);
      check("bidir_hold_cmd_ready", cmd_ready, 0);
    end
    core_rx_ready = 1'b1;
    @(negedge clk);
    check("bidir_cmd_ready_after_push", cmd_ready, 1);
    check("bidir_push_count", rx_words.size(), 1);
    check("bidir_word", rx_words[0], 32'hA4A3A2A1);
    check_tx("bidir_tx", 64'h0D0C0B0A, 4);

    // Soft reset mid-segment: partial RX dropped, TX holding register emptied.
    rx_words.delete();
    tx_bytes.delete();
    sr_tx_ready = 1'b0;
    tx_mem[5] = {32'h12345678, 4'hF};
    tx_wr = 4'd6;
    issue_cmd(2'b11, 9'd7);
    send_rx(8'hB1); send_rx(8'hB2);
    sw_rst = 1'b1;
    tx_wr  = tx_rd;
    @(negedge clk);
    sw_rst = 1'b0;
    check("swrst_cmd_ready", cmd_ready, 1);
    check("swrst_busy", busy, 0);
    check("swrst_rx_valid", core_rx_valid, 0);
    check("swrst_sr_tx_valid", sr_tx_valid, 0);
    @(negedge clk);
    check("swrst_no_push", rx_words.size(), 0);
    tx_mem[6] = {32'h000000EE, 4'b0001};
    tx_wr = 4'd7;
    sr_tx_ready = 1'b1;
    issue_cmd(2'b10, 9'd0);
    wait_idle();
    check_tx("swrst_tx", 64'hEE, 1);
    check("swrst_pops", tx_pops, 7);

    // Dummy segment: accepted in one cycle, no data movement.
    tx_bytes.delete();
    tx_mem[7] = {32'hCAFEF00D, 4'hF};
    tx_wr = 4'd8;
    sr_rx_valid = 1'b1;
    sr_rx_byte = 8'h5A;
    issue_cmd(2'b00, 9'd3);
    for (int i = 0; i < 3; i++) begin
      check("dummy_cmd_ready", cmd_ready, 1);
      check("dummy_busy", busy, 0);
      check("dummy_tx_pop", core_tx_ready, 0);
      check("dummy_sr_rx_ready", sr_rx_ready, 0);
      @(negedge clk);
    end
    check("dummy_pops", tx_pops, 7);
    check("dummy_tx_bytes", tx_bytes.size(), 0);
    check("dummy_rx_words", rx_words.size(), 0);
    sr_rx_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
